// File: rtl/stream_traffic_gen.sv
// Stream traffic generator: replays RAM words into a DUT input stream under a programmable
// valid gate, throttles the DUT output stream with a ready gate, and tracks beats and passes.
module stream_traffic_gen #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PER_W     = 16,
    localparam int unsigned ADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_total,
    input  logic [CNT_W-1:0]  cfg_expect,
    input  logic [1:0]        cfg_src_mode,
    input  logic [1:0]        cfg_snk_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PER_W-1:0]  cfg_src_on,
    input  logic [PER_W-1:0]  cfg_snk_on,
    input  logic              cfg_restart_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic              busy,
    output logic              done,
    output logic              err_mismatch,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [CNT_W-1:0]  pass_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              hold_q, hold_d;
    logic [PER_W-1:0]  phase_q, phase_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, pass_cnt_q, pass_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  total_q, total_d, expect_q, expect_d;
    logic [1:0]        src_mode_q, src_mode_d, snk_mode_q, snk_mode_d;
    logic [PER_W-1:0]  period_q, period_d, src_on_q, src_on_d, snk_on_q, snk_on_d;

    logic              src_duty, snk_duty, src_gate, snk_gate;
    logic              m_pop, s_hs, rd_issue, enter_run, start_ok;
    logic [2:0]        occ;
    logic [PER_W:0]    phase_inc;

    assign busy         = (state_q == StRun) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign err_mismatch = err_q;
    assign in_cnt       = in_cnt_q;
    assign out_cnt      = out_cnt_q;
    assign pass_cnt     = pass_cnt_q;

    always_comb begin
        src_duty = (period_q == '0) || (src_on_q >= period_q) || (phase_q < src_on_q);
        snk_duty = (period_q == '0) || (snk_on_q >= period_q) || (phase_q < snk_on_q);
        unique case (src_mode_q)
            2'd1:    src_gate = src_duty;
            2'd2:    src_gate = lfsr_q[0];
            default: src_gate = 1'b1;
        endcase
        unique case (snk_mode_q)
            2'd1:    snk_gate = snk_duty;
            2'd2:    snk_gate = lfsr_q[8];
            default: snk_gate = 1'b1;
        endcase
        // Once offered, a beat stays offered regardless of the gate until it is taken.
        m_valid  = (fifo_cnt_q != 2'd0) && (src_gate || hold_q);
        m_data   = m_valid ? fifo_q[fifo_rptr_q] : '0;
        m_last   = m_valid && (in_cnt_q == total_q - CNT_W'(1));
        s_ready  = busy && snk_gate;
        m_pop    = m_valid && m_ready;
        s_hs     = s_valid && s_ready;
        // Count the slot freed by this cycle's pop so a steady stream needs no bubbles.
        occ      = {1'b0, fifo_cnt_q} + {2'b0, rd_pend_q} - {2'b0, m_pop};
        rd_issue = (state_q == StRun) && (occ < 3'd2) && (rd_cnt_q != total_q);
    end

    always_comb begin
        state_d     = state_q;
        fifo_d      = fifo_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        fifo_cnt_d  = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, m_pop};
        rd_pend_d   = rd_issue;
        rd_addr_d   = rd_addr_q;
        rd_cnt_d    = rd_cnt_q;
        hold_d      = m_valid && !m_ready;
        phase_d     = phase_q;
        lfsr_d      = lfsr_q;
        in_cnt_d    = in_cnt_q + CNT_W'(m_pop);
        out_cnt_d   = out_cnt_q + CNT_W'(s_hs);
        pass_cnt_d  = pass_cnt_q;
        err_d       = err_q;
        total_d     = total_q;
        expect_d    = expect_q;
        src_mode_d  = src_mode_q;
        snk_mode_d  = snk_mode_q;
        period_d    = period_q;
        src_on_d    = src_on_q;
        snk_on_d    = snk_on_q;
        enter_run   = 1'b0;
        start_ok    = 1'b0;
        phase_inc   = {1'b0, phase_q} + {{PER_W{1'b0}}, 1'b1};

        if (rd_pend_q) begin
            fifo_d[fifo_wptr_q] = rd_data_q;
            fifo_wptr_d         = !fifo_wptr_q;
        end
        if (m_pop) fifo_rptr_d = !fifo_rptr_q;
        if (rd_issue) begin
            rd_addr_d = (rd_addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
            rd_cnt_d  = rd_cnt_q + CNT_W'(1);
        end
        if (busy) begin
            phase_d = (phase_inc >= {1'b0, period_q}) ? '0 : phase_inc[PER_W-1:0];
            lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end

        unique case (state_q)
            StIdle: begin
                if (start && (cfg_total != '0)) begin
                    state_d   = StRun;
                    enter_run = 1'b1;
                    start_ok  = 1'b1;
                end
            end
            StRun: begin
                if (m_pop && (in_cnt_q == total_q - CNT_W'(1))) state_d = StDrain;
            end
            StDrain: begin
                if (s_hs && s_last) state_d = StDone;
            end
            StDone: begin
                pass_cnt_d = pass_cnt_q + CNT_W'(1);
                if (out_cnt_q != expect_q) err_d = 1'b1;
                if (cfg_restart_en) begin
                    state_d   = StRun;
                    enter_run = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_run) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            rd_addr_d = '0;
            rd_cnt_d  = '0;
            phase_d   = '0;
        end
        if (start_ok) begin
            err_d      = 1'b0;
            pass_cnt_d = '0;
            lfsr_d     = 16'hACE1;
            total_d    = cfg_total;
            expect_d   = cfg_expect;
            src_mode_d = cfg_src_mode;
            snk_mode_d = cfg_snk_mode;
            period_d   = cfg_period;
            src_on_d   = cfg_src_on;
            snk_on_d   = cfg_snk_on;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !busy) mem_q[mem_waddr] <= mem_wdata;
        if (rd_issue) rd_data_q <= mem_q[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fifo_q      <= '{default: '0};
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            hold_q      <= 1'b0;
            phase_q     <= '0;
            lfsr_q      <= 16'hACE1;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            err_q       <= 1'b0;
            total_q     <= '0;
            expect_q    <= '0;
            src_mode_q  <= '0;
            snk_mode_q  <= '0;
            period_q    <= '0;
            src_on_q    <= '0;
            snk_on_q    <= '0;
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            lfsr_q      <= lfsr_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            err_q       <= err_d;
            total_q     <= total_d;
            expect_q    <= expect_d;
            src_mode_q  <= src_mode_d;
            snk_mode_q  <= snk_mode_d;
            period_q    <= period_d;
            src_on_q    <= src_on_d;
            snk_on_q    <= snk_on_d;
        end
    end

endmodule

// File: tb/tb_stream_traffic_gen.sv
// Bench for stream_traffic_gen: random traffic against a beat-level reference model with an
// echoing sink that returns every accepted word and flags the final one with s_last.
module tb_stream_traffic_gen;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 32;
    localparam int unsigned PW    = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_waddr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_total = '0, cfg_expect = '0;
    logic [1:0]    cfg_src_mode = '0, cfg_snk_mode = '0;
    logic [PW-1:0] cfg_period = '0, cfg_src_on = '0, cfg_snk_on = '0;
    logic          cfg_restart_en = 1'b0;
    logic          m_valid, m_last, s_ready, busy, done, err_mismatch;
    logic          m_ready = 1'b0, s_valid = 1'b0, s_last = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] in_cnt, out_cnt, pass_cnt;

    stream_traffic_gen #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .CNT_W(CW), .PER_W(PW)) dut (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .start(start), .cfg_total(cfg_total), .cfg_expect(cfg_expect),
        .cfg_src_mode(cfg_src_mode), .cfg_snk_mode(cfg_snk_mode), .cfg_period(cfg_period),
        .cfg_src_on(cfg_src_on), .cfg_snk_on(cfg_snk_on), .cfg_restart_en(cfg_restart_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .busy(busy), .done(done),
        .err_mismatch(err_mismatch), .in_cnt(in_cnt), .out_cnt(out_cnt), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0, n_errors = 0;

    // Reference model state
    logic [DW-1:0] ram_m [DEPTH];
    logic [DW-1:0] echo_q [$];
    logic [DW-1:0] prev_data;
    logic [15:0]   mlfsr;
    bit            known = 0, m_busy = 0, m_done_now = 0, m_err = 0, hold_prev = 0;
    int unsigned   k, idx, m_out, m_pass, m_total, m_expect, m_per, m_son, m_kon;
    bit [1:0]      m_smode, m_kmode;
    int unsigned   echo_idx, echo_n, first_k, last_k, dut_ndone = 0;
    int            mr_pol = 0, sv_pol = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h1;
        return (l >> 1) | (fb << 15);
    endfunction

    function automatic bit gate(input bit [1:0] mode, input int unsigned on, input int b);
        if (mode == 2'd1) return (m_per == 0) || (on >= m_per) || ((k % m_per) < on);
        if (mode == 2'd2) return mlfsr[b];
        return 1'b1;
    endfunction

    task automatic enter_run(input bit full);
        m_busy = 1; k = 0; idx = 0; m_out = 0; echo_idx = 0;
        if (full) begin
            mlfsr = 16'hACE1; m_pass = 0; m_err = 0;
            m_total = cfg_total; m_expect = cfg_expect; m_smode = cfg_src_mode;
            m_kmode = cfg_snk_mode; m_per = cfg_period; m_son = cfg_src_on;
            m_kon = cfg_snk_on; echo_n = cfg_total;
        end
    endtask

    // One clock cycle: drive sink-side inputs, check outputs, advance the model.
    task automatic tick();
        bit mhs, shs, was_busy, drain_before, nxt_done;
        unique case (mr_pol)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        s_valid = (echo_q.size() != 0) && (sv_pol == 0 || $urandom_range(0, 2) != 0);
        s_last  = s_valid && (echo_idx == echo_n - 1);
        #1;
        if (known && !reset) begin
            check_eq("busy", busy, m_busy);
            check_eq("done", done, m_done_now);
            check_eq("in_cnt", in_cnt, idx);
            check_eq("out_cnt", out_cnt, m_out);
            check_eq("pass_cnt", pass_cnt, m_pass);
            check_eq("err_mismatch", err_mismatch, m_err);
            if (!m_busy) begin
                check_eq("idle_m_valid", m_valid, 0);
                check_eq("idle_s_ready", s_ready, 0);
                check_eq("idle_m_data", m_data, 0);
            end else begin
                check_eq("s_ready_gate", s_ready, gate(m_kmode, m_kon, 8));
                if (hold_prev) begin
                    check_eq("hold_valid", m_valid, 1);
                    check_eq("hold_data", m_data, prev_data);
                end else begin
                    check_eq("valid_gated", m_valid && !gate(m_smode, m_son, 0), 0);
                end
                if (idx == m_total) check_eq("valid_after_end", m_valid, 0);
                if (m_valid) begin
                    check_eq("m_data", m_data, ram_m[idx % DEPTH]);
                    check_eq("m_last", m_last, idx == m_total - 1);
                    if (idx == 0) check_eq("first_valid_lat", k >= 2, 1);
                end
            end
        end
        if (done === 1'b1) dut_ndone++;
        mhs = m_valid && m_ready;
        shs = s_valid && s_ready;
        if (reset) begin
            known = 1; m_busy = 0; m_done_now = 0; m_err = 0; hold_prev = 0;
            idx = 0; m_out = 0; m_pass = 0; mlfsr = 16'hACE1; echo_idx = 0;
            echo_q.delete();
        end else begin
            was_busy = m_busy;
            nxt_done = 0;
            if (mem_we && !m_busy) ram_m[mem_waddr] = mem_wdata;
            hold_prev = m_busy && m_valid && !m_ready;
            prev_data = m_data;
            if (m_busy) begin
                drain_before = (idx == m_total);
                if (mhs) begin
                    echo_q.push_back(m_data);
                    if (idx == 0) first_k = k;
                    last_k = k;
                    idx++;
                end
                if (shs) begin
                    void'(echo_q.pop_front());
                    m_out++;
                    if (s_last) begin
                        echo_idx = 0;
                        if (drain_before) begin
                            m_busy = 0;
                            nxt_done = 1;
                        end
                    end else begin
                        echo_idx++;
                    end
                end
                k++;
                mlfsr = lfsr_next(mlfsr);
            end
            if (m_done_now) begin
                m_pass++;
                if (m_out != m_expect) m_err = 1;
                if (cfg_restart_en) enter_run(0);
            end else if (start && !was_busy && cfg_total != 0) begin
                enter_run(1);
            end
            m_done_now = nxt_done;
        end
        @(negedge clk);
    endtask

    task automatic start_pass(input int unsigned total, input int unsigned expect_n,
                              input bit [1:0] smode, input bit [1:0] kmode,
                              input int unsigned per, input int unsigned son,
                              input int unsigned kon);
        cfg_total = total; cfg_expect = expect_n; cfg_src_mode = smode; cfg_snk_mode = kmode;
        cfg_period = PW'(per); cfg_src_on = PW'(son); cfg_snk_on = PW'(kon);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        while ((m_busy || m_done_now) && n < budget) begin
            tick();
            n++;
        end
        check_eq("pass_timeout", m_busy || m_done_now, 0);
    endtask

    task automatic load_ram(input bit random_data);
        for (int i = 0; i < DEPTH; i++) begin
            mem_we = 1'b1; mem_waddr = AW'(i);
            mem_wdata = random_data ? {$urandom, $urandom} : DW'(i);
            tick();
        end
        mem_we = 1'b0;
    endtask

    initial begin
        int unsigned d0, saved;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_pass_cnt", pass_cnt, 0);

        // Basic pass at full throughput
        load_ram(0);
        d0 = dut_ndone;
        start_pass(8, 8, 0, 0, 0, 0, 0);
        run_to_idle(200);
        check_eq("t1_done_pulses", dut_ndone - d0, 1);
        check_eq("t1_throughput", last_k - first_k, 7);
        check_eq("t1_in_cnt", in_cnt, 8);
        check_eq("t1_out_cnt", out_cnt, 8);
        check_eq("t1_err", err_mismatch, 0);

        // Source duty gating; a RAM write and a start while busy must both be ignored
        load_ram(1);
        start_pass(200, 200, 1, 0, 512, 64, 0);
        repeat (10) tick();
        mem_we = 1'b1; mem_waddr = 4'd3; mem_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        start = 1'b1; cfg_total = 5;
        tick();
        mem_we = 1'b0; start = 1'b0;
        run_to_idle(4000);
        check_eq("t2_in_cnt", in_cnt, 200);
        check_eq("t2_pass_cnt", pass_cnt, 1);

        // Back-pressure hold
        mr_pol = 2;
        start_pass(12, 12, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        check_eq("t3_valid_seen", m_valid, 1);
        saved = in_cnt;
        repeat (5) tick();
        check_eq("t3_in_cnt_held", in_cnt, saved);
        check_eq("t3_valid_held", m_valid, 1);
        mr_pol = 0;
        run_to_idle(300);

        // Address wrap with random handshakes
        mr_pol = 1; sv_pol = 1;
        start_pass(40, 40, 0, 0, 0, 0, 0);
        run_to_idle(1000);
        check_eq("t4_in_cnt", in_cnt, 40);

        // LFSR gating on both sides, then sink duty gating
        start_pass(30, 30, 2, 2, 0, 0, 0);
        run_to_idle(2000);
        start_pass(25, 25, 0, 1, 5, 0, 2);
        run_to_idle(2000);
        check_eq("t5_out_cnt", out_cnt, 25);

        // Automatic restart for three passes with a mismatched expectation
        mr_pol = 0; sv_pol = 0;
        cfg_restart_en = 1'b1;
        d0 = dut_ndone;
        start_pass(8, 9, 0, 0, 0, 0, 0);
        for (int n = 0; (m_busy || m_done_now) && n < 3000; n++) begin
            tick();
            if (dut_ndone - d0 >= 2) cfg_restart_en = 1'b0;
        end
        check_eq("t6_idle", busy, 0);
        check_eq("t6_done_pulses", dut_ndone - d0, 3);
        check_eq("t6_pass_cnt", pass_cnt, 3);
        check_eq("t6_err", err_mismatch, 1);

        // Reset mid-run, then start with a zero beat count
        start_pass(100, 100, 0, 0, 0, 0, 0);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_eq("t7_busy", busy, 0);
        check_eq("t7_in_cnt", in_cnt, 0);
        check_eq("t7_out_cnt", out_cnt, 0);
        check_eq("t7_pass_cnt", pass_cnt, 0);
        check_eq("t7_m_valid", m_valid, 0);
        check_eq("t7_m_data", m_data, 0);
        start_pass(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check_eq("t7_zero_total", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
